// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_param
//  Purpose  : Single-clock synchronous FIFO with parametrised width and any
//             depth >= 2 (non-power-of-two allowed). Provides programmable
//             almost-full/almost-empty thresholds, optional first-word-fall-
//             through read mode, and registered write-ack/overflow/underflow.
//  Ports    : clk         - clock, all logic on rising edge
//             rst         - synchronous active-high reset
//             din         - write data
//             wr_en       - write request
//             rd_en       - read request
//             dout        - read data (registered, or head word when FWFT=1)
//             count       - current occupancy
//             full        - count == FIFO_DEPTH
//             empty       - count == 0
//             almostfull  - count >= AF_THRESH and not full
//             almostempty - count <= AE_THRESH and not empty
//             wr_ack      - previous-cycle write accepted
//             overflow    - previous-cycle write rejected
//             underflow   - previous-cycle read rejected
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_param #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int AF_THRESH  = FIFO_DEPTH - 1,
   parameter int AE_THRESH  = 1,
   parameter int FWFT       = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [FIFO_WIDTH-1:0]                din,
   input  logic                                 wr_en,
   input  logic                                 rd_en,
   output logic [FIFO_WIDTH-1:0]                dout,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
   output logic                                 full,
   output logic                                 empty,
   output logic                                 almostfull,
   output logic                                 almostempty,
   output logic                                 wr_ack,
   output logic                                 overflow,
   output logic                                 underflow
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
   localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);
   localparam logic [PW-1:0] C_LAST  = PW'(FIFO_DEPTH - 1);

   // Reject configurations that would make the flags meaningless.
   if (FIFO_DEPTH < 2 ||
       AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH - 1 ||
       AE_THRESH < 1 || AE_THRESH > FIFO_DEPTH - 1) begin : g_param_check
      $fatal(1, "fifo_param: illegal FIFO_DEPTH or threshold parameter");
   end

   logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          wr_ack_q, overflow_q, underflow_q;
   logic          rd_ok, wr_ok;

   // Flags decode the registered count, so they line up with count itself.
   assign full        = (count_q == C_DEPTH);
   assign empty       = (count_q == '0);
   assign almostfull  = (count_q >= C_AF) && !full;
   assign almostempty = (count_q <= C_AE) && !empty;

   // A simultaneous read frees the slot, so a full FIFO still takes a write.
   assign rd_ok = rd_en && !empty;
   assign wr_ok = wr_en && (!full || rd_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Explicit wrap compare keeps non-power-of-two depths correct.
      if (wr_ok) wr_ptr_d = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + PW'(1);
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wr_ack_q    <= wr_ok;
         overflow_q  <= wr_en && !wr_ok;
         underflow_q <= rd_en && !rd_ok;
      end
   end

   // Storage is not reset; a write coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   if (FWFT == 0) begin : g_reg_rd
      logic [FIFO_WIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q <= '0;
         end else if (rd_ok) begin
            dout_q <= mem_q[rd_ptr_q];
         end
      end
      assign dout = dout_q;
   end else begin : g_fwft_rd
      // Head word is presented directly; rd_en only advances the pointer.
      assign dout = empty ? '0 : mem_q[rd_ptr_q];
   end

   assign count     = count_q;
   assign wr_ack    = wr_ack_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_param
//  Purpose  : Directed self-checking bench for fifo_param. Instance A uses the
//             default configuration (depth 8, registered read); instance B
//             uses depth 5, FWFT, AF_THRESH=3, AE_THRESH=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // Instance A (defaults)
   logic [15:0] a_din = '0;
   logic        a_wr = 1'b0, a_rd = 1'b0;
   logic [15:0] a_dout;
   logic [3:0]  a_count;
   logic        a_full, a_empty, a_af, a_ae, a_ack, a_ovf, a_udf;

   // Instance B (depth 5, FWFT)
   logic [15:0] b_din = '0;
   logic        b_wr = 1'b0, b_rd = 1'b0;
   logic [15:0] b_dout;
   logic [2:0]  b_count;
   logic        b_full, b_empty, b_af, b_ae, b_ack, b_ovf, b_udf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_param u_a (
      .clk(clk), .rst(rst), .din(a_din), .wr_en(a_wr), .rd_en(a_rd),
      .dout(a_dout), .count(a_count), .full(a_full), .empty(a_empty),
      .almostfull(a_af), .almostempty(a_ae), .wr_ack(a_ack),
      .overflow(a_ovf), .underflow(a_udf)
   );

   fifo_param #(
      .FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(1)
   ) u_b (
      .clk(clk), .rst(rst), .din(b_din), .wr_en(b_wr), .rd_en(b_rd),
      .dout(b_dout), .count(b_count), .full(b_full), .empty(b_empty),
      .almostfull(b_af), .almostempty(b_ae), .wr_ack(b_ack),
      .overflow(b_ovf), .underflow(b_udf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic b_chk(input string tag, input int cnt, input logic [15:0] d,
                        input logic af, input logic ae);
      check({tag, " count"}, 32'(b_count), 32'(cnt));
      check({tag, " dout"},  32'(b_dout),  32'(d));
      check({tag, " af"},    32'(b_af),    32'(af));
      check({tag, " ae"},    32'(b_ae),    32'(ae));
   endtask

   initial begin
      // ---------------- reset ----------------
      tick(); tick();
      rst = 1'b0;
      check("rst count", 32'(a_count), 0);
      check("rst empty", 32'(a_empty), 1);
      check("rst full",  32'(a_full),  0);
      check("rst af",    32'(a_af),    0);
      check("rst ae",    32'(a_ae),    0);
      check("rst wr_ack", 32'(a_ack),  0);
      check("rst ovf",   32'(a_ovf),   0);
      check("rst udf",   32'(a_udf),   0);
      check("rst dout",  32'(a_dout),  0);
      check("rst B empty", 32'(b_empty), 1);
      check("rst B dout",  32'(b_dout),  0);

      // ---------------- test 1: fill ----------------
      a_wr = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         a_din = 16'(i);
         tick();
         check("t1 wr_ack", 32'(a_ack), 1);
         check("t1 count",  32'(a_count), 32'(i));
         if (i == 1) check("t1 ae@1", 32'(a_ae), 1);
         if (i == 7) begin
            check("t1 af@7",   32'(a_af),   1);
            check("t1 full@7", 32'(a_full), 0);
         end
      end
      check("t1 full@8", 32'(a_full), 1);
      check("t1 af@8",   32'(a_af),   0);
      a_din = 16'h0009;
      tick();
      check("t1 ovf",       32'(a_ovf),   1);
      check("t1 ovf ack",   32'(a_ack),   0);
      check("t1 ovf count", 32'(a_count), 8);
      a_wr = 1'b0;
      tick();
      check("t1 ovf pulse", 32'(a_ovf), 0);

      // ---------------- test 2: drain ----------------
      a_rd = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("t2 dout",  32'(a_dout),  32'(i));
         check("t2 count", 32'(a_count), 32'(8 - i));
         if (i == 7) check("t2 ae@1", 32'(a_ae), 1);
      end
      check("t2 empty", 32'(a_empty), 1);
      check("t2 ae@0",  32'(a_ae),    0);
      tick();
      check("t2 udf",       32'(a_udf),  1);
      check("t2 udf dout",  32'(a_dout), 16'h0008);
      a_rd = 1'b0;
      tick();
      check("t2 udf pulse", 32'(a_udf), 0);

      // ---------------- test 3: full, simultaneous rd/wr ----------------
      a_wr = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         a_din = 16'(16'h0010 + i);
         tick();
      end
      check("t3 full", 32'(a_full), 1);
      a_rd = 1'b1;
      a_din = 16'h00AA;
      tick();
      check("t3 count", 32'(a_count), 8);
      check("t3 ack",   32'(a_ack),   1);
      check("t3 ovf",   32'(a_ovf),   0);
      check("t3 dout",  32'(a_dout),  16'h0011);
      a_wr = 1'b0;
      for (int i = 2; i <= 8; i++) begin
         tick();
         check("t3 drain", 32'(a_dout), 32'(16'h0010 + i));
      end
      tick();
      check("t3 last",  32'(a_dout),  16'h00AA);
      check("t3 count0", 32'(a_count), 0);

      // ---------------- test 4: empty, simultaneous rd/wr ----------------
      a_wr = 1'b1;
      a_din = 16'h0055;
      tick();
      check("t4 count", 32'(a_count), 1);
      check("t4 ack",   32'(a_ack),   1);
      check("t4 udf",   32'(a_udf),   1);
      check("t4 dout",  32'(a_dout),  16'h00AA);
      a_rd = 1'b0;

      // bring A to count 4 for the reset test
      for (int i = 0; i < 3; i++) begin
         a_din = 16'(16'h0056 + i);
         tick();
      end
      a_wr = 1'b0;
      check("t6 pre count", 32'(a_count), 4);

      // ---------------- test 5: depth 5, FWFT ----------------
      b_wr = 1'b1; b_din = 16'h00B1; tick(); b_chk("t5 w1", 1, 16'h00B1, 0, 1);
      b_din = 16'h00B2; tick();              b_chk("t5 w2", 2, 16'h00B1, 0, 1);
      b_din = 16'h00B3; tick();              b_chk("t5 w3", 3, 16'h00B1, 1, 0);
      b_din = 16'h00B4; tick();              b_chk("t5 w4", 4, 16'h00B1, 1, 0);
      check("t5 full@4", 32'(b_full), 0);
      b_rd = 1'b1;
      b_din = 16'h00B5; tick();              b_chk("t5 wr5", 4, 16'h00B2, 1, 0);
      b_din = 16'h00B6; tick();              b_chk("t5 wr6", 4, 16'h00B3, 1, 0);
      b_wr = 1'b0;
      tick();                                b_chk("t5 r3", 3, 16'h00B4, 1, 0);
      tick();                                b_chk("t5 r4", 2, 16'h00B5, 0, 1);
      tick();                                b_chk("t5 r5", 1, 16'h00B6, 0, 1);
      b_rd = 1'b0; b_wr = 1'b1; b_din = 16'h00B7;
      tick();                                b_chk("t5 w7", 2, 16'h00B6, 0, 1);
      b_wr = 1'b0; b_rd = 1'b1;
      tick();                                b_chk("t5 r6", 1, 16'h00B7, 0, 1);
      tick();                                b_chk("t5 r7", 0, 16'h0000, 0, 0);
      check("t5 empty", 32'(b_empty), 1);
      tick();
      check("t5 udf", 32'(b_udf), 1);
      b_rd = 1'b0;

      // ---------------- test 6: reset mid-operation ----------------
      a_wr = 1'b1; a_din = 16'h0077; rst = 1'b1;
      tick();
      check("t6 count", 32'(a_count), 0);
      check("t6 empty", 32'(a_empty), 1);
      check("t6 ack",   32'(a_ack),   0);
      check("t6 ovf",   32'(a_ovf),   0);
      check("t6 dout",  32'(a_dout),  0);
      rst = 1'b0; a_wr = 1'b0;
      tick();
      check("t6 post ack",   32'(a_ack),   0);
      check("t6 post count", 32'(a_count), 0);
      a_wr = 1'b1; a_din = 16'h0099;
      tick();
      a_wr = 1'b0; a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
      check("t6 fresh dout", 32'(a_dout), 16'h0099);
      check("t6 fresh count", 32'(a_count), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
